// File: rtl/cost_table.sv
// ---------------------------------------------------------------------------
// cost_table
//   Holds an N x N table of job costs for a downstream assignment engine.
//   The table is streamed in row-major order, one cost per accepted beat, and
//   is then frozen and readable combinationally by {W,J}.  While loading, the
//   block accumulates LowerBound = sum over rows of each row's minimum cost.
//
// Ports
//   CLK         clock, rising edge
//   RST         asynchronous active-low reset
//   CLR         synchronous request to discard the table and reload it
//   DIN_VALID   load beat present
//   DIN         cost value of the current load beat
//   DIN_READY   load beat accepted this cycle (combinational)
//   W, J        worker / job index of the lookup
//   Cost        table[W][J] while Ready, else 0 (combinational)
//   Ready       table fully loaded (registered)
//   LowerBound  sum of row minima (registered, valid while Ready)
// ---------------------------------------------------------------------------
module cost_table #(
  parameter int N  = 8,
  parameter int CW = 7
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CLR,
  input  logic                 DIN_VALID,
  input  logic [CW-1:0]        DIN,
  output logic                 DIN_READY,
  input  logic [$clog2(N)-1:0] W,
  input  logic [$clog2(N)-1:0] J,
  output logic [CW-1:0]        Cost,
  output logic                 Ready,
  output logic [9:0]           LowerBound
);

  localparam int IW  = $clog2(N);
  localparam int AW  = $clog2(N*N);
  localparam int LBW = 10;

  typedef enum logic [0:0] {
    ST_LOAD  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Smaller of two cost values.
  function automatic logic [CW-1:0] min_cost(input logic [CW-1:0] a,
                                             input logic [CW-1:0] b);
    if (a < b) begin
      min_cost = a;
    end else begin
      min_cost = b;
    end
  endfunction

  state_t          state_q, state_d;
  logic [AW-1:0]   wp_q, wp_d;
  logic [CW-1:0]   rowmin_q, rowmin_d;
  logic [LBW-1:0]  lb_q, lb_d;
  logic            ready_q, ready_d;
  logic [CW-1:0]   mem_q [0:N*N-1];

  logic            din_ready_s;
  logic            accept_s;
  logic [IW-1:0]   jpos_s;
  logic [CW-1:0]   row_low_s;

  // RST gating keeps DIN_READY low during reset independent of the clock.
  assign din_ready_s = RST && (state_q == ST_LOAD) && !CLR;
  assign accept_s    = DIN_VALID && din_ready_s;
  assign jpos_s      = wp_q[IW-1:0];
  assign row_low_s   = min_cost(rowmin_q, DIN);

  // Next-state logic for FSM, write pointer, row minimum and lower bound.
  always_comb begin
    state_d  = state_q;
    wp_d     = wp_q;
    rowmin_d = rowmin_q;
    lb_d     = lb_q;
    if (CLR) begin
      state_d  = ST_LOAD;
      wp_d     = {AW{1'b0}};
      rowmin_d = {CW{1'b0}};
      lb_d     = {LBW{1'b0}};
    end else if (accept_s) begin
      // wp wraps to 0 naturally on the last beat of the table.
      wp_d = wp_q + AW'(1);
      if (jpos_s == IW'(0)) begin
        rowmin_d = DIN;
      end else begin
        rowmin_d = row_low_s;
      end
      if (jpos_s == IW'(N-1)) begin
        lb_d = lb_q + LBW'(row_low_s);
      end else begin
        lb_d = lb_q;
      end
      if (wp_q == AW'(N*N-1)) begin
        state_d = ST_READY;
      end else begin
        state_d = state_q;
      end
    end else begin
      state_d = state_q;
    end
    ready_d = (state_d == ST_READY);
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_LOAD;
      wp_q     <= {AW{1'b0}};
      rowmin_q <= {CW{1'b0}};
      lb_q     <= {LBW{1'b0}};
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wp_q     <= wp_d;
      rowmin_q <= rowmin_d;
      lb_q     <= lb_d;
      ready_q  <= ready_d;
    end
  end

  // Table storage; deliberately not reset, written only by accepted beats.
  always_ff @(posedge CLK) begin
    if (accept_s) begin
      mem_q[wp_q] <= DIN;
    end
  end

  assign DIN_READY  = din_ready_s;
  assign Ready      = ready_q;
  assign LowerBound = lb_q;
  assign Cost       = ready_q ? mem_q[{W, J}] : {CW{1'b0}};

endmodule

// File: tb/tb_cost_table.sv
module tb_cost_table;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       CLR = 1'b0;
  logic       DIN_VALID = 1'b0;
  logic [6:0] DIN = 7'd0;
  logic       DIN_READY;
  logic [2:0] W = 3'd0;
  logic [2:0] J = 3'd0;
  logic [6:0] Cost;
  logic       Ready;
  logic [9:0] LowerBound;

  int total = 0;
  int bad   = 0;
  int beats [64];

  cost_table #(.N(8), .CW(7)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .CLR        (CLR),
    .DIN_VALID  (DIN_VALID),
    .DIN        (DIN),
    .DIN_READY  (DIN_READY),
    .W          (W),
    .J          (J),
    .Cost       (Cost),
    .Ready      (Ready),
    .LowerBound (LowerBound)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock, then settle 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic lookup(input string tag, input int w, input int j, input int exp);
    W = 3'(w);
    J = 3'(j);
    #1;
    check_eq(tag, int'(Cost), exp);
  endtask

  // Stream beats[0..cnt-1]; optional idle cycle before each beat.
  task automatic load(input int cnt, input bit gaps);
    for (int k = 0; k < cnt; k++) begin
      if (gaps) begin
        DIN_VALID = 1'b0;
        DIN       = 7'd99;
        tick();
      end
      DIN_VALID = 1'b1;
      DIN       = 7'(beats[k]);
      #1;
      if (k == 0)  check_eq("din_ready_load", int'(DIN_READY), 1);
      if (k == 63) check_eq("ready_before_last", int'(Ready), 0);
      tick();
    end
    DIN_VALID = 1'b0;
  endtask

  task automatic do_clr();
    CLR       = 1'b1;
    DIN_VALID = 1'b1;
    DIN       = 7'd5;
    #1;
    check_eq("din_ready_clr", int'(DIN_READY), 0);
    tick();
    CLR       = 1'b0;
    DIN_VALID = 1'b0;
  endtask

  initial begin
    // Reset state
    DIN_VALID = 1'b1;
    #2;
    check_eq("rst_ready", int'(Ready), 0);
    check_eq("rst_lb", int'(LowerBound), 0);
    check_eq("rst_cost", int'(Cost), 0);
    check_eq("rst_din_ready", int'(DIN_READY), 0);
    DIN_VALID = 1'b0;
    tick();
    tick();
    RST = 1'b1;

    // Ascending load k%128
    for (int k = 0; k < 64; k++) beats[k] = k % 128;
    load(64, 1'b0);
    check_eq("asc_ready", int'(Ready), 1);
    check_eq("asc_lb", int'(LowerBound), 224);
    check_eq("asc_din_ready", int'(DIN_READY), 0);
    lookup("asc_cost_3_5", 3, 5, 29);
    lookup("asc_cost_0_0", 0, 0, 0);
    lookup("asc_cost_7_7", 7, 7, 63);

    // Beats while ready are ignored
    DIN_VALID = 1'b1;
    DIN       = 7'd111;
    tick();
    tick();
    DIN_VALID = 1'b0;
    lookup("frozen_cost_3_5", 3, 5, 29);
    lookup("frozen_cost_0_0", 0, 0, 0);
    check_eq("frozen_lb", int'(LowerBound), 224);

    // CLR with simultaneous beat
    do_clr();
    check_eq("clr_ready", int'(Ready), 0);
    check_eq("clr_lb", int'(LowerBound), 0);
    lookup("clr_cost", 3, 5, 0);

    // Reload with stalls; dropped beat must not shift the table
    load(64, 1'b1);
    check_eq("gap_ready", int'(Ready), 1);
    check_eq("gap_lb", int'(LowerBound), 224);
    lookup("gap_cost_3_5", 3, 5, 29);
    lookup("gap_cost_0_1", 0, 1, 1);

    // Row 2 = {90,4,90,...}, rest 127
    do_clr();
    for (int k = 0; k < 64; k++) beats[k] = 127;
    for (int k = 16; k < 24; k++) beats[k] = 90;
    beats[17] = 4;
    load(64, 1'b0);
    check_eq("row2_lb", int'(LowerBound), 893);
    lookup("row2_cost_2_1", 2, 1, 4);
    lookup("row2_cost_2_0", 2, 0, 90);
    lookup("row2_cost_1_1", 1, 1, 127);

    // Async reset mid-load after 30 beats
    do_clr();
    for (int k = 0; k < 64; k++) beats[k] = 127;
    load(30, 1'b0);
    check_eq("mid_lb", int'(LowerBound), 381);
    #2;
    RST = 1'b0;
    #1;
    check_eq("arst_lb", int'(LowerBound), 0);
    check_eq("arst_ready", int'(Ready), 0);
    check_eq("arst_din_ready", int'(DIN_READY), 0);
    check_eq("arst_cost", int'(Cost), 0);
    tick();
    RST = 1'b1;
    beats[0] = 11;
    load(64, 1'b0);
    check_eq("restart_ready", int'(Ready), 1);
    check_eq("restart_lb", int'(LowerBound), 900);
    lookup("restart_cost_0_0", 0, 0, 11);
    lookup("restart_cost_0_1", 0, 1, 127);

    // All 127: maximum lower bound
    do_clr();
    beats[0] = 127;
    load(64, 1'b0);
    check_eq("max_lb", int'(LowerBound), 1016);
    check_eq("max_din_ready", int'(DIN_READY), 0);
    for (int p = 0; p < 3; p++) begin
      DIN_VALID = 1'b1;
      DIN       = 7'(p);
      tick();
      DIN_VALID = 1'b0;
      tick();
    end
    lookup("max_cost_0_0", 0, 0, 127);
    lookup("max_cost_7_7", 7, 7, 127);
    check_eq("max_lb_hold", int'(LowerBound), 1016);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cost_table.md
COST_TABLE -- requirements
Module: cost_table

Interface
Parameters:
REQ-001 N, 8, number of workers and jobs; the table holds N*N entries.
REQ-002 CW, 7, cost entry width in bits.
Ports (name  direction  width  meaning):
REQ-003 CLK  input  1  single clock; every register updates on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low; deasserts synchronously to CLK.
REQ-005 CLR  input  1  synchronous request to discard the table and reload it.
REQ-006 DIN_VALID  input  1  load beat is present.
REQ-007 DIN  input  7  cost value of the current load beat.
REQ-008 DIN_READY  output  1  block accepts a load beat this cycle.
REQ-009 W  input  3  worker index of the lookup.
REQ-010 J  input  3  job index of the lookup.
REQ-011 Cost  output  7  cost entry selected by {W,J}.
REQ-012 Ready  output  1  table is fully loaded; the downstream assignment engine holds its reset until this is high.
REQ-013 LowerBound  output  10  sum over all rows of each row's minimum cost.

Function
REQ-014 FSM states are LOAD and READY; RST low forces LOAD.
REQ-015 A beat is accepted when DIN_VALID && DIN_READY; DIN_READY = (state==LOAD) && !CLR, combinationally.
REQ-016 Beats arrive in row-major order; beat k writes entry [k/N][k%N], held by a 6-bit write pointer wp.
REQ-017 wp increments by 1 per accepted beat; DIN_VALID low stalls the load with no state change.
REQ-018 LOAD->READY on the cycle after the beat with wp==63 is accepted; wp wraps to 0 on that beat.
REQ-019 In READY, DIN_READY is 0 and DIN/DIN_VALID are ignored; the table contents are frozen.
REQ-020 READY->LOAD on CLR; CLR in LOAD restarts the load at wp=0.
REQ-021 CLR clears wp, LowerBound, the row-min register and Ready on the next edge; it does not clear the table storage.
REQ-022 If CLR and DIN_VALID are high in the same cycle, CLR wins and the beat is dropped.
REQ-023 Cost = table[W][J] combinationally (zero cycle latency) while Ready=1; Cost = 0 while Ready=0.
REQ-024 rowmin register: on the beat with J-position 0 it loads DIN; on later beats of the row it loads min(rowmin, DIN).
REQ-025 On the beat with J-position N-1, LowerBound += min(rowmin, DIN), zero-extended to 10 bits.
REQ-026 LowerBound needs no saturation: the maximum is 8*127=1016 < 1024.
REQ-027 LowerBound is updated only in LOAD and is constant and valid while Ready=1.
REQ-028 Ready is registered and equals (state==READY).

Reset
REQ-029 While RST is low, regardless of CLK: state=LOAD, wp=0, rowmin=0, LowerBound=0, Ready=0, Cost=0, DIN_READY=0.
REQ-030 Table storage is not reset; its content is undefined until loaded.
REQ-031 RST low during a load aborts the load; after release, loading restarts from entry 0.

Verification
REQ-032 Reset release, then 64 back-to-back beats DIN=k%128 -> Ready rises one cycle after the 64th beat; W=3,J=5 gives Cost=29; LowerBound=0+8+16+...+56=224.
REQ-033 Same load with DIN_VALID low on every other cycle -> same table, same LowerBound; Ready rises one cycle after the 64th accepted beat.
REQ-034 All beats 127 except row 2, which is {90,4,90,...} -> LowerBound=7*127+4=893; Cost at (2,1)=4.
REQ-035 After Ready, assert CLR for 1 cycle together with DIN_VALID=1 -> beat dropped, Ready=0, LowerBound=0, wp=0; a reload of 64 beats brings Ready high again.
REQ-036 Assert RST low after 30 beats -> outputs at reset values immediately (asynchronously); after release, beat 0 writes entry (0,0).
REQ-037 All 64 beats =127 -> LowerBound=1016 with no overflow; DIN_READY=0 while Ready=1, and further DIN_VALID pulses leave Cost unchanged.
